// File: rtl/ber_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ber_pkg
// Purpose : Shared constants for the BER measurement accumulator: FSM state
//           encodings, bits per checker word and checker error-count width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ber_pkg;

   // Measurement FSM state encodings
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
   localparam logic [1:0] ST_RUN       = 2'd2;
   localparam logic [1:0] ST_DONE      = 2'd3;

   // Bits compared per checker word and width of the checker error count
   localparam int BITS_PER_WORD = 8;
   localparam int ERR_W         = 9;

endpackage : ber_pkg
`default_nettype wire

// File: rtl/sat_accum.sv
`default_nettype none
// ============================================================================
// Module  : sat_accum
// Purpose : Saturating accumulator with synchronous clear and a sticky flag
//           that is set once the accumulator reaches all-ones.
// Ports   : clk      - clock
//           reset    - synchronous active-high reset
//           clr_i    - clear accumulator and flag (wins over add_en_i)
//           add_en_i - add add_i this cycle
//           add_i    - unsigned addend, IN_W bits (may be wider than W)
//           acc_o    - accumulated value, W bits
//           sat_o    - sticky saturation flag
// Revision: 1.0 - initial release
// ============================================================================
module sat_accum #(
   parameter int W    = 8,
   parameter int IN_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr_i,
   input  logic            add_en_i,
   input  logic [IN_W-1:0] add_i,
   output logic [W-1:0]    acc_o,
   output logic            sat_o
);

   // One guard bit above the wider operand so any overflow is visible
   localparam int SW = ((W > IN_W) ? W : IN_W) + 1;

   logic [SW-1:0] sum_d;
   logic [W-1:0]  acc_d;
   logic [W-1:0]  acc_q;
   logic          sat_q;

   always_comb begin
      sum_d = SW'(acc_q) + SW'(add_i);
      acc_d = (|sum_d[SW-1:W]) ? {W{1'b1}} : sum_d[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         acc_q <= '0;
         sat_q <= 1'b0;
      end else if (add_en_i) begin
         acc_q <= acc_d;
         sat_q <= sat_q | (&acc_d);
      end
   end

   assign acc_o = acc_q;
   assign sat_o = sat_q;

endmodule : sat_accum
`default_nettype wire

// File: rtl/ber_counter.sv
`default_nettype none
// ============================================================================
// Module  : ber_counter
// Purpose : BER measurement accumulator fed by the PRBS checker. Over a
//           software-set window of valid words it accumulates compared bits,
//           errored bits and lock-loss events, then holds them for readout.
// Ports   : clk       - clock, all logic on posedge
//           reset     - synchronous active-high reset
//           start_i   - pulse: clear counters, latch win_len_i, arm
//           stop_i    - pulse: end measurement early
//           win_len_i - window length in valid words, 0 = free-run
//           err_num_i - errored bits in the current checker word
//           lock_i    - checker lock
//           valid_i   - checker word valid
//           bit_cnt_o - compared bits (saturating)
//           err_cnt_o - errored bits (saturating)
//           loss_cnt_o- lock 1->0 transitions while running (saturating)
//           busy_o    - waiting for lock or running
//           done_o    - one-cycle pulse on entering DONE
//           sat_o     - sticky, any counter reached all-ones
// Revision: 1.0 - initial release
// ============================================================================
module ber_counter
   import ber_pkg::*;
#(
   parameter int CNT_W  = 48,
   parameter int WIN_W  = 32,
   parameter int LOSS_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [WIN_W-1:0]  win_len_i,
   input  logic [ERR_W-1:0]  err_num_i,
   input  logic              lock_i,
   input  logic              valid_i,
   output logic [CNT_W-1:0]  bit_cnt_o,
   output logic [CNT_W-1:0]  err_cnt_o,
   output logic [LOSS_W-1:0] loss_cnt_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              sat_o
);

   localparam int BPW_W = $clog2(BITS_PER_WORD + 1);
   localparam logic [BPW_W-1:0] BPW = BPW_W'(BITS_PER_WORD);

   logic [1:0]       state_q, state_d;
   logic             done_q, done_d;
   logic             lock_dly_q;
   logic [WIN_W-1:0] words_q, words_inc;
   logic [WIN_W-1:0] win_lat_q;
   logic             accept, loss_evt, win_hit;
   logic             bit_sat, err_sat, loss_sat;

   // Valid is only meaningful with lock; gating also keeps unlocked words out
   assign accept    = (state_q == ST_RUN) && valid_i && lock_i;
   assign loss_evt  = (state_q == ST_RUN) && lock_dly_q && !lock_i;
   assign words_inc = (&words_q) ? words_q : words_q + 1'b1;
   assign win_hit   = accept && (win_lat_q != '0) && (words_inc == win_lat_q);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (stop_i)      state_d = ST_DONE;
            else if (lock_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (stop_i || win_hit) state_d = ST_DONE;
         end
         default: state_d = state_q;
      endcase
      if (start_i) state_d = ST_WAIT_LOCK;
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
   end

   assign done_o = done_q;
   assign busy_o = (state_q == ST_WAIT_LOCK) || (state_q == ST_RUN);

   // ---------------- lock history, word count, window ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_dly_q <= 1'b0;
         words_q    <= '0;
         win_lat_q  <= '0;
      end else begin
         lock_dly_q <= lock_i;
         if (start_i) begin
            words_q   <= '0;
            win_lat_q <= win_len_i;
         end else if (accept) begin
            words_q <= words_inc;
         end
      end
   end

   // ---------------- counters ----------------
   sat_accum #(.W(CNT_W), .IN_W(BPW_W)) u_bit_acc (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (start_i),
      .add_en_i (accept),
      .add_i    (BPW),
      .acc_o    (bit_cnt_o),
      .sat_o    (bit_sat)
   );

   sat_accum #(.W(CNT_W), .IN_W(ERR_W)) u_err_acc (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (start_i),
      .add_en_i (accept),
      .add_i    (err_num_i),
      .acc_o    (err_cnt_o),
      .sat_o    (err_sat)
   );

   sat_accum #(.W(LOSS_W), .IN_W(1)) u_loss_acc (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (start_i),
      .add_en_i (loss_evt),
      .add_i    (1'b1),
      .acc_o    (loss_cnt_o),
      .sat_o    (loss_sat)
   );

   assign sat_o = bit_sat | err_sat | loss_sat;

endmodule : ber_counter
`default_nettype wire

// File: tb/tb_ber_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ber_counter
// Purpose : Self-checking bench for ber_counter. A default-width instance and
//           an 8-bit counter instance share stimulus; expected final counts
//           are queued per measurement and compared at the done pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ber_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, stop, lock, valid;
   logic [31:0] win_len;
   logic [8:0]  err_num;

   logic [47:0] bit_cnt, err_cnt;
   logic [15:0] loss_cnt;
   logic        busy, done, sat;
   logic [7:0]  bit8, err8;
   logic [15:0] loss8;
   logic        busy8, done8, sat8;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [47:0] bits;
      logic [47:0] errs;
      logic [15:0] loss;
      logic        sat;
      logic [7:0]  bits8;
      logic [7:0]  errs8;
      logic        sat8;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   ber_counter dut (
      .clk(clk), .reset(reset), .start_i(start), .stop_i(stop),
      .win_len_i(win_len), .err_num_i(err_num), .lock_i(lock), .valid_i(valid),
      .bit_cnt_o(bit_cnt), .err_cnt_o(err_cnt), .loss_cnt_o(loss_cnt),
      .busy_o(busy), .done_o(done), .sat_o(sat)
   );

   ber_counter #(.CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .start_i(start), .stop_i(stop),
      .win_len_i(win_len), .err_num_i(err_num), .lock_i(lock), .valid_i(valid),
      .bit_cnt_o(bit8), .err_cnt_o(err8), .loss_cnt_o(loss8),
      .busy_o(busy8), .done_o(done8), .sat_o(sat8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] w);
      start   = 1'b1;
      win_len = w;
      tick();
      start   = 1'b0;
   endtask

   task automatic word(input logic [8:0] e);
      valid   = 1'b1;
      err_num = e;
      tick();
      valid   = 1'b0;
      err_num = '0;
   endtask

   task automatic push(input logic [47:0] b, input logic [47:0] e, input logic [15:0] l,
                       input logic s, input logic [7:0] b8, input logic [7:0] e8, input logic s8);
      exp_t x;
      x.bits = b; x.errs = e; x.loss = l; x.sat = s;
      x.bits8 = b8; x.errs8 = e8; x.sat8 = s8;
      sb.push_back(x);
   endtask

   // Bounded wait for done, then pop the expected result and compare
   task automatic wait_done(input string tag);
      int   n;
      exp_t x;
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      check({tag, " done"}, done, 1);
      check({tag, " done latency"}, n, 0);
      check({tag, " done8"}, done8, 1);
      check({tag, " sb depth"}, sb.size(), 1);
      if (sb.size() > 0) begin
         x = sb.pop_front();
         check({tag, " bit_cnt"}, bit_cnt, x.bits);
         check({tag, " err_cnt"}, err_cnt, x.errs);
         check({tag, " loss_cnt"}, loss_cnt, x.loss);
         check({tag, " sat"}, sat, x.sat);
         check({tag, " bit8"}, bit8, x.bits8);
         check({tag, " err8"}, err8, x.errs8);
         check({tag, " sat8"}, sat8, x.sat8);
      end
      tick();
      check({tag, " done low"}, done, 0);
      check({tag, " busy low"}, busy, 0);
      check({tag, " held bit_cnt"}, bit_cnt, x.bits);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; lock = 1'b0; valid = 1'b0;
      win_len = '0; err_num = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst bit_cnt", bit_cnt, 0);
      check("rst err_cnt", err_cnt, 0);
      check("rst loss_cnt", loss_cnt, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst sat", sat, 0);

      // Basic window of 4 clean words
      do_start(32'd4);
      check("basic busy wait", busy, 1);
      lock = 1'b1;
      tick();
      push(48'd32, 48'd0, 16'd0, 1'b0, 8'd32, 8'd0, 1'b0);
      for (int i = 0; i < 4; i++) word(9'd0);
      wait_done("basic");

      // Errors on two of ten words
      do_start(32'd10);
      tick();
      push(48'd80, 48'd6, 16'd0, 1'b0, 8'd80, 8'd6, 1'b0);
      for (int i = 0; i < 10; i++) word((i == 2 || i == 5) ? 9'd3 : 9'd0);
      wait_done("errors");

      // Two lock drops of three cycles each, six locked words
      do_start(32'd6);
      tick();
      push(48'd48, 48'd0, 16'd2, 1'b0, 8'd48, 8'd0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         word(9'd0);
         word(9'd0);
         if (k < 2) begin
            lock = 1'b0;
            for (int j = 0; j < 3; j++) tick();
            check("loss busy", busy, 1);
            lock = 1'b1;
         end
      end
      wait_done("lockloss");

      // Saturation visible on the 8-bit instance only
      do_start(32'd3);
      tick();
      push(48'd24, 48'd600, 16'd0, 1'b0, 8'd24, 8'd255, 1'b1);
      for (int i = 0; i < 3; i++) word(9'd200);
      wait_done("saturate");

      // Free-run ended by stop
      do_start(32'd0);
      tick();
      push(48'd40, 48'd0, 16'd0, 1'b0, 8'd40, 8'd0, 1'b0);
      for (int i = 0; i < 5; i++) word(9'd1 * 9'(i));
      tick(); tick();
      check("freerun no done", done, 0);
      check("freerun busy", busy, 1);
      sb[0].errs  = 48'd10;
      sb[0].errs8 = 8'd10;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done("freerun");

      // start and stop together: start wins
      start = 1'b1; stop = 1'b1; win_len = 32'd0;
      tick();
      start = 1'b0; stop = 1'b0;
      check("prio bit_cnt", bit_cnt, 0);
      check("prio err_cnt", err_cnt, 0);
      check("prio busy", busy, 1);
      check("prio done", done, 0);
      check("prio sat8", sat8, 0);
      word(9'd0);               // sampled in WAIT_LOCK: must be ignored
      check("waitlock ignores valid", bit_cnt, 0);

      // Reset in the middle of a run
      word(9'd1);
      word(9'd1);
      check("prereset bit_cnt", bit_cnt, 16);
      check("prereset err_cnt", err_cnt, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst bit_cnt", bit_cnt, 0);
      check("midrst err_cnt", err_cnt, 0);
      check("midrst busy", busy, 0);
      check("midrst done", done, 0);
      word(9'd5);
      word(9'd5);
      check("postrst bit_cnt", bit_cnt, 0);
      check("postrst err_cnt", err_cnt, 0);
      check("postrst done", done, 0);
      check("postrst busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_ber_counter
`default_nettype wire
